count_event_monitor: RTL

Downstream observer for the 4-bit up/down counter. It samples `Count` every cycle and classifies each transition as hold, step, wrap or direction change. It keeps saturating wrap statistics and queues timestamped event records in a small first-word-fall-through FIFO with a valid/ready interface, so a slower consumer (UART logger, debug bus) can drain them.

---
 rtl/count_event_monitor.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/count_event_monitor.sv
// count_event_monitor: classifies transitions of an up/down counter as hold,
// step, wrap or direction change. Keeps saturating wrap counts and queues
// timestamped event records in a first-word-fall-through FIFO (valid/ready).
// Optional feature: define COUNT_MON_ILLEGAL_EN to report non-unit deltas as
// code 00 events; by default such deltas are ignored.
module count_event_monitor #(
    parameter int unsigned WIDTH      = 4,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned STAMP_W    = 8
) (
    input  logic                 Clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     Count,
    output logic                 ev_valid,
    input  logic                 ev_ready,
    output logic [STAMP_W+1:0]   ev_data,
    output logic [STAMP_W-1:0]   up_wraps,
    output logic [STAMP_W-1:0]   down_wraps,
    output logic                 overflow
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned DW = STAMP_W + 2;
    localparam logic [WIDTH-1:0]   MAX = '1;
    localparam logic [STAMP_W-1:0] SAT = '1;

    localparam logic [1:0] CODE_ILLEGAL    = 2'b00;
    localparam logic [1:0] CODE_UP_WRAP    = 2'b01;
    localparam logic [1:0] CODE_DOWN_WRAP  = 2'b10;
    localparam logic [1:0] CODE_DIR_CHANGE = 2'b11;

    typedef enum logic [1:0] {DIR_NONE, DIR_UP, DIR_DOWN} dir_t;

    logic [WIDTH-1:0]   prev;
    logic               prev_valid;
    dir_t               last_dir, last_dir_nxt;
    logic [STAMP_W-1:0] stamp;

    logic               step_up, step_down;
    logic               up_wrap_hit, down_wrap_hit;
    logic               push;
    logic [1:0]         push_code;
    logic [DW-1:0]      push_word;

    logic [DW-1:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]      wr_ptr, rd_ptr;
    logic [CW-1:0]      occ, occ_nxt;
    logic               pop, full, accept, drop;
    logic [DW-1:0]      head_nxt;

    // Transition classification and event selection (ILLEGAL > WRAP > DIR_CHANGE)
    always_comb begin
        last_dir_nxt  = last_dir;
        push          = 1'b0;
        push_code     = CODE_ILLEGAL;
        up_wrap_hit   = 1'b0;
        down_wrap_hit = 1'b0;
        step_up       = (Count == prev + WIDTH'(1));
        step_down     = (Count == prev - WIDTH'(1));
        if (prev_valid) begin
            if (step_up) begin
                last_dir_nxt = DIR_UP;
                if (prev == MAX) begin
                    up_wrap_hit = 1'b1;
                    push        = 1'b1;
                    push_code   = CODE_UP_WRAP;
                end else if (last_dir == DIR_DOWN) begin
                    push      = 1'b1;
                    push_code = CODE_DIR_CHANGE;
                end
            end else if (step_down) begin
                last_dir_nxt = DIR_DOWN;
                if (prev == '0) begin
                    down_wrap_hit = 1'b1;
                    push          = 1'b1;
                    push_code     = CODE_DOWN_WRAP;
                end else if (last_dir == DIR_UP) begin
                    push      = 1'b1;
                    push_code = CODE_DIR_CHANGE;
                end
            end else if (Count != prev) begin
`ifdef COUNT_MON_ILLEGAL_EN
                push      = 1'b1;
                push_code = CODE_ILLEGAL;
`else
                push      = 1'b0;
`endif
            end
        end
        push_word = {push_code, stamp};
    end

    // FIFO control and next registered head; a push into an empty (or
    // draining-to-empty) FIFO becomes the head on the following cycle
    always_comb begin
        pop    = ev_valid && ev_ready;
        full   = (occ == CW'(FIFO_DEPTH));
        accept = push && (!full || pop);
        drop   = push && full && !pop;
        case ({accept, pop})
            2'b10:   occ_nxt = occ + CW'(1);
            2'b01:   occ_nxt = occ - CW'(1);
            default: occ_nxt = occ;
        endcase
        if (occ_nxt == '0) begin
            head_nxt = '0;
        end else if (accept && ((occ == '0) || (pop && (occ == CW'(1))))) begin
            head_nxt = push_word;
        end else if (pop) begin
            head_nxt = mem[rd_ptr + AW'(1)];
        end else begin
            head_nxt = ev_data;
        end
    end

    // Direction state register
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) last_dir <= DIR_NONE;
        else       last_dir <= last_dir_nxt;
    end

    // Sample history, timestamp, wrap statistics, FIFO pointers and outputs
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            prev       <= '0;
            prev_valid <= 1'b0;
            stamp      <= '0;
            up_wraps   <= '0;
            down_wraps <= '0;
            overflow   <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            occ        <= '0;
            ev_valid   <= 1'b0;
            ev_data    <= '0;
        end else begin
            prev       <= Count;
            prev_valid <= 1'b1;
            stamp      <= stamp + STAMP_W'(1);
            if (up_wrap_hit && (up_wraps != SAT))
                up_wraps <= up_wraps + STAMP_W'(1);
            if (down_wrap_hit && (down_wraps != SAT))
                down_wraps <= down_wraps + STAMP_W'(1);
            if (drop)
                overflow <= 1'b1;
            if (accept)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            occ      <= occ_nxt;
            ev_valid <= (occ_nxt != '0);
            ev_data  <= head_nxt;
        end
    end

    // FIFO storage; contents are only read while valid, so no reset needed
    always_ff @(posedge Clk) begin
        if (accept)
            mem[wr_ptr] <= push_word;
    end

endmodule
